elevator_car: RTL

- Car/shaft plant model that sits at the opposite end of the elevator controller interface.
- Consumes the controller's dir_up, dir_down and door_open commands.
- Produces the cur_floor feedback the controller reads, plus motion and door status.
- Models floor-to-floor travel time and door motion time, and flags illegal command combinations; used as the closed-loop partner of the controller in system benches.

---
 rtl/elevator_car.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/elevator_car.sv
// ============================================================================
//  Module   : elevator_car
//  Brief    : Car/shaft plant model driven by elevator controller commands.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_car #(
    parameter int TOP_FLOOR  = 2,
    parameter int FLOOR_W    = 2,
    parameter int TRAVEL_CYC = 1000,
    parameter int DOOR_CYC   = 500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dir_up,
    input  logic               dir_down,
    input  logic               door_open,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               moving,
    output logic               door_is_open,
    output logic               door_closed,
    output logic               arrived,
    output logic               fault
);

    localparam int c_max_cyc = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int c_cnt_w   = $clog2(c_max_cyc) + 1;

    localparam logic [c_cnt_w-1:0] c_travel_load = c_cnt_w'(TRAVEL_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_door_load   = c_cnt_w'(DOOR_CYC - 1);
    localparam logic [FLOOR_W-1:0] c_top         = FLOOR_W'(TOP_FLOOR);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_move_up   = 3'd1;
    localparam logic [2:0] c_st_move_down = 3'd2;
    localparam logic [2:0] c_st_opening   = 3'd3;
    localparam logic [2:0] c_st_open      = 3'd4;
    localparam logic [2:0] c_st_closing   = 3'd5;

    logic [2:0]         r_state,  w_state;
    logic [c_cnt_w-1:0] r_cnt,    w_cnt;
    logic [FLOOR_W-1:0] r_floor,  w_floor;
    logic               r_moving, w_moving;
    logic               r_open,   w_open;
    logic               r_closed, w_closed;
    logic               r_arrived, w_arrived;
    logic               r_fault,  w_fault;

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_floor   = r_floor;
        w_moving  = r_moving;
        w_open    = r_open;
        w_closed  = r_closed;
        w_arrived = 1'b0;
        w_fault   = r_fault;

        case (r_state)
            c_st_idle: begin
                // Conflicting or out-of-range requests are refused, never acted on.
                if ((dir_up && dir_down) || ((dir_up || dir_down) && door_open)) begin
                    w_fault = 1'b1;
                end else if ((dir_up && r_floor == c_top) || (dir_down && r_floor == '0)) begin
                    w_fault = 1'b1;
                end else if (dir_up) begin
                    w_state  = c_st_move_up;
                    w_cnt    = c_travel_load;
                    w_moving = 1'b1;
                end else if (dir_down) begin
                    w_state  = c_st_move_down;
                    w_cnt    = c_travel_load;
                    w_moving = 1'b1;
                end else if (door_open) begin
                    w_state  = c_st_opening;
                    w_cnt    = c_door_load;
                    w_closed = 1'b0;
                end
            end

            c_st_move_up, c_st_move_down: begin
                if (door_open ||
                    (r_state == c_st_move_up   && dir_down) ||
                    (r_state == c_st_move_down && dir_up)) begin
                    w_fault = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_floor   = (r_state == c_st_move_up) ? r_floor + 1'b1 : r_floor - 1'b1;
                    w_arrived = 1'b1;
                    w_moving  = 1'b0;
                    w_state   = c_st_idle;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end

            c_st_opening: begin
                if (dir_up || dir_down) w_fault = 1'b1;
                if (r_cnt == '0) begin
                    w_open  = 1'b1;
                    w_state = c_st_open;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end

            c_st_open: begin
                if (dir_up || dir_down) w_fault = 1'b1;
                if (!door_open) begin
                    w_open  = 1'b0;
                    w_cnt   = c_door_load;
                    w_state = c_st_closing;
                end
            end

            c_st_closing: begin
                if (dir_up || dir_down) w_fault = 1'b1;
                // A reopen request wins even on the final closing cycle.
                if (door_open) begin
                    w_cnt   = c_door_load;
                    w_state = c_st_opening;
                end else if (r_cnt == '0) begin
                    w_closed = 1'b1;
                    w_state  = c_st_idle;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end

            default: begin
                w_state = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_floor   <= '0;
            r_moving  <= 1'b0;
            r_open    <= 1'b0;
            r_closed  <= 1'b1;
            r_arrived <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_floor   <= w_floor;
            r_moving  <= w_moving;
            r_open    <= w_open;
            r_closed  <= w_closed;
            r_arrived <= w_arrived;
            r_fault   <= w_fault;
        end
    end

    assign cur_floor    = r_floor;
    assign moving       = r_moving;
    assign door_is_open = r_open;
    assign door_closed  = r_closed;
    assign arrived      = r_arrived;
    assign fault        = r_fault;

endmodule

`default_nettype wire
